// File: rtl/dq_pkg.sv
// Shared constants, zigzag map, product reduction and FSM state for the 4x4 dequantizer.
// DQ_SATURATE_EN selects clamping instead of two's-complement wrap in sat16.
package dq_pkg;

    localparam int BLK_COEFS = 16;
    localparam int COEF_W    = 16;

    localparam logic [3:0] ZIGZAG [BLK_COEFS] = '{
        4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
        4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
    };

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } dq_state_t;

    function automatic logic [COEF_W-1:0] sat16(input logic signed [32:0] p);
`ifdef DQ_SATURATE_EN
        if (p > 33'sd32767) begin
            return 16'h7fff;
        end else if (p < -33'sd32768) begin
            return 16'h8000;
        end else begin
            return p[COEF_W-1:0];
        end
`else
        // Wrap keeps reconstruction bit-exact with the encoder's truncated path.
        return p[COEF_W-1:0];
`endif
    endfunction

endpackage

// File: rtl/dq_lane.sv
// One dequantizer lane: signed level times unsigned step, reduced to 16 bits.
// Purely combinational, zero latency, no flow control.
module dq_lane
    import dq_pkg::*;
(
    input  logic signed [COEF_W-1:0] level_i,
    input  logic        [COEF_W-1:0] step_i,
    output logic        [COEF_W-1:0] coef_o
);

    logic signed [32:0] lvl_ext;
    logic signed [32:0] step_ext;
    logic signed [32:0] prod;

    // The exact product of s16 x u16 always fits in 33 signed bits.
    assign lvl_ext  = $signed({{17{level_i[COEF_W-1]}}, level_i});
    assign step_ext = $signed({17'd0, step_i});
    assign prod     = lvl_ext * step_ext;
    assign coef_o   = sat16(prod);

endmodule

// File: rtl/dequant_dezigzag_block.sv
// Dequantize 16 zigzag levels over LANES multipliers, write raster coefs; done NBEATS+1 cycles after start.
// Start is ignored while busy and in the done cycle; DQ_SATURATE_EN selects clamping over wrap.
module dequant_dezigzag_block
    import dq_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] level_in,
    input  logic [255:0] q,
    output logic         busy,
    output logic [255:0] coef,
    output logic         nz,
    output logic [3:0]   last_nz,
    output logic         done
);

    localparam int NBEATS = BLK_COEFS / LANES;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    dq_state_t          state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               nz_q, nz_d;
    logic [3:0]         last_q, last_d;
    logic [COEF_W-1:0]  level_q [BLK_COEFS];
    logic [COEF_W-1:0]  level_d [BLK_COEFS];
    logic [COEF_W-1:0]  q_q     [BLK_COEFS];
    logic [COEF_W-1:0]  q_d     [BLK_COEFS];
    logic [COEF_W-1:0]  coef_q  [BLK_COEFS];
    logic [COEF_W-1:0]  coef_d  [BLK_COEFS];

    logic [3:0]         lane_k    [LANES];
    logic [COEF_W-1:0]  lane_lvl  [LANES];
    logic [COEF_W-1:0]  lane_step [LANES];
    logic [COEF_W-1:0]  lane_coef [LANES];

    // Lane l handles zigzag position beat*LANES+l; its step is looked up in raster order.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_k[l]    = 4'(int'(beat_q) * LANES + l);
            lane_lvl[l]  = level_q[lane_k[l]];
            lane_step[l] = q_q[ZIGZAG[lane_k[l]]];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        dq_lane u_lane (
            .level_i (lane_lvl[l]),
            .step_i  (lane_step[l]),
            .coef_o  (lane_coef[l])
        );
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        nz_d    = nz_q;
        last_d  = last_q;
        level_d = level_q;
        q_d     = q_q;
        coef_d  = coef_q;

        case (state_q)
            IDLE: begin
                // done_q high marks the one-cycle window where start must still be ignored.
                if (start && !done_q) begin
                    for (int i = 0; i < BLK_COEFS; i++) begin
                        level_d[i] = level_in[16*i +: 16];
                        q_d[i]     = q[16*i +: 16];
                        coef_d[i]  = '0;
                    end
                    nz_d    = 1'b0;
                    last_d  = '0;
                    beat_d  = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                for (int l = 0; l < LANES; l++) begin
                    coef_d[ZIGZAG[lane_k[l]]] = lane_coef[l];
                    if (lane_lvl[l] != '0) begin
                        nz_d = 1'b1;
                        if (lane_k[l] > last_d) begin
                            last_d = lane_k[l];
                        end
                    end
                end
                if (beat_q == BEAT_W'(NBEATS - 1)) begin
                    state_d = FIN;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            nz_q    <= 1'b0;
            last_q  <= '0;
            level_q <= '{default: '0};
            q_q     <= '{default: '0};
            coef_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            nz_q    <= nz_d;
            last_q  <= last_d;
            level_q <= level_d;
            q_q     <= q_d;
            coef_q  <= coef_d;
        end
    end

    for (genvar i = 0; i < BLK_COEFS; i++) begin : g_pack
        assign coef[16*i +: 16] = coef_q[i];
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign nz      = nz_q;
    assign last_nz = last_q;

endmodule

// File: tb/tb_dequant_dezigzag_block.sv
// Directed bench for dequant_dezigzag_block at LANES=4, 1 and 16 side by side.
module tb_dequant_dezigzag_block;

    logic         clk = 1'b0;
    logic [2:0]   rst_v;
    logic [2:0]   start_v;
    logic [255:0] level_in;
    logic [255:0] q;
    logic [2:0]   busy_w;
    logic [2:0]   nz_w;
    logic [2:0]   done_w;
    logic [3:0]   last_w [3];
    logic [255:0] coef_w [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
        dequant_dezigzag_block #(.LANES(L)) u_dut (
            .clk      (clk),
            .rst_n    (rst_v[g]),
            .start    (start_v[g]),
            .level_in (level_in),
            .q        (q),
            .busy     (busy_w[g]),
            .coef     (coef_w[g]),
            .nz       (nz_w[g]),
            .last_nz  (last_w[g]),
            .done     (done_w[g])
        );
    end

    typedef struct {
        logic [255:0] lvl;
        logic [255:0] qv;
        logic [255:0] coef;
        logic         nz;
        logic [3:0]   last;
    } vec_t;

    vec_t tbl [5];
    logic [3:0] zz_tb [16];

    function automatic int nbeats(input int sel);
        return (sel == 0) ? 4 : ((sel == 1) ? 16 : 1);
    endfunction

    function automatic logic [255:0] put(input logic [255:0] v, input int i, input logic [15:0] x);
        logic [255:0] r;
        r = v;
        r[16*i +: 16] = x;
        return r;
    endfunction

    function automatic logic [255:0] fill(input logic [15:0] x);
        logic [255:0] r;
        for (int i = 0; i < 16; i++) r[16*i +: 16] = x;
        return r;
    endfunction

    task automatic chk(input string nm, input int sel, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, sel, act, exp);
        end
    endtask

    task automatic run_block(input int sel, input vec_t v, input string tag);
        int lat;
        logic [255:0] held;
        @(negedge clk);
        level_in = v.lvl;
        q        = v.qv;
        start_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_v[sel] = 1'b0;
        chk({tag, "_busy"}, sel, 256'(busy_w[sel]), 256'd1);
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (done_w[sel]) begin
                lat = c;
                break;
            end
        end
        chk({tag, "_latency"}, sel, 256'(lat), 256'(nbeats(sel) + 1));
        chk({tag, "_busy_at_done"}, sel, 256'(busy_w[sel]), 256'd0);
        chk({tag, "_coef"}, sel, coef_w[sel], v.coef);
        chk({tag, "_nz"}, sel, 256'(nz_w[sel]), 256'(v.nz));
        chk({tag, "_last_nz"}, sel, 256'(last_w[sel]), 256'(v.last));
        held = coef_w[sel];
        level_in = ~v.lvl;
        q        = ~v.qv;
        @(posedge clk);
        #1;
        chk({tag, "_done_width"}, sel, 256'(done_w[sel]), 256'd0);
        chk({tag, "_hold"}, sel, coef_w[sel], v.coef);
        if (held !== v.coef) chk({tag, "_hold_pre"}, sel, held, v.coef);
    endtask

    task automatic handshake(input int sel);
        int d;
        logic [255:0] exp_a;
        logic [255:0] exp_c;
        d = nbeats(sel) + 1;
        exp_a = put(256'd0, 4, 16'd30);
        exp_c = put(256'd0, 0, 16'hfffb);
        @(negedge clk);
        level_in = put(256'd0, 2, 16'd3);
        q        = fill(16'd10);
        start_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_v[sel] = 1'b0;
        level_in = fill(16'd5);
        q        = fill(16'd9);
        for (int c = 1; c <= 2 * d + 3; c++) begin
            if (c == 1) begin
                start_v[sel] = 1'b1;
            end
            @(posedge clk);
            #1;
            if (c == 2) start_v[sel] = 1'b0;
            chk("hs_done", sel, 256'(done_w[sel]), 256'((c == d) || (c == 2 * d + 2)));
            if (c == 2) chk("hs_busy_second_start", sel, 256'(busy_w[sel]), 256'(d > 2));
            if (c == d) begin
                chk("hs_coef_first", sel, coef_w[sel], exp_a);
                level_in = put(256'd0, 0, 16'hffff);
                q        = fill(16'd5);
                start_v[sel] = 1'b1;
            end
            if (c == d + 1) chk("hs_start_in_done_ignored", sel, 256'(busy_w[sel]), 256'd0);
            if (c == d + 2) begin
                chk("hs_start_after_done", sel, 256'(busy_w[sel]), 256'd1);
                start_v[sel] = 1'b0;
            end
            if (c == 2 * d + 2) begin
                chk("hs_coef_second", sel, coef_w[sel], exp_c);
                chk("hs_nz_second", sel, 256'(nz_w[sel]), 256'd1);
                chk("hs_last_second", sel, 256'(last_w[sel]), 256'd0);
            end
        end
    endtask

    task automatic mid_reset(input int sel);
        int rc;
        int dcnt;
        rc = (nbeats(sel) >= 3) ? 2 : 0;
        @(negedge clk);
        level_in = tbl[2].lvl;
        q        = tbl[2].qv;
        start_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_v[sel] = 1'b0;
        for (int i = 0; i < rc; i++) begin
            @(posedge clk);
            #1;
        end
        rst_v[sel] = 1'b0;
        #1;
        chk("rst_coef", sel, coef_w[sel], 256'd0);
        chk("rst_nz", sel, 256'(nz_w[sel]), 256'd0);
        chk("rst_last", sel, 256'(last_w[sel]), 256'd0);
        chk("rst_busy", sel, 256'(busy_w[sel]), 256'd0);
        chk("rst_done", sel, 256'(done_w[sel]), 256'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_v[sel] = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done_w[sel]) dcnt++;
        end
        chk("rst_no_done", sel, 256'(dcnt), 256'd0);
        run_block(sel, tbl[0], "post_rst");
    endtask

    initial begin
        zz_tb = '{4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
                  4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15};
        rst_v    = '0;
        start_v  = '0;
        level_in = '0;
        q        = '0;

        // single level at zigzag 2 -> raster 4
        tbl[0].lvl  = put(256'd0, 2, 16'd3);
        tbl[0].qv   = fill(16'd10);
        tbl[0].coef = put(256'd0, 4, 16'd30);
        tbl[0].nz   = 1'b0 | 1'b1;
        tbl[0].last = 4'd2;
        // all-zero levels
        tbl[1].lvl = '0;
        for (int r = 0; r < 16; r++) tbl[1].qv[16*r +: 16] = 16'(3 * r + 1);
        tbl[1].coef = '0;
        tbl[1].nz   = 1'b0;
        tbl[1].last = 4'd0;
        // signed levels k-8 against q=r+1
        tbl[2].lvl = '0;
        tbl[2].coef = '0;
        for (int r = 0; r < 16; r++) tbl[2].qv[16*r +: 16] = 16'(r + 1);
        for (int k = 0; k < 16; k++) begin
            tbl[2].lvl[16*k +: 16] = 16'(k - 8);
            tbl[2].coef[16*zz_tb[k] +: 16] = 16'((k - 8) * (int'(zz_tb[k]) + 1));
        end
        tbl[2].nz   = 1'b1;
        tbl[2].last = 4'd15;
        // +/-2047 * 100 overflows 16 bits
        tbl[3].lvl = put(put(256'd0, 0, 16'd2047), 1, 16'hf801);
        tbl[3].qv  = fill(16'd100);
`ifdef DQ_SATURATE_EN
        tbl[3].coef = put(put(256'd0, 0, 16'h7fff), 1, 16'h8000);
`else
        tbl[3].coef = put(put(256'd0, 0, 16'd8092), 1, 16'he064);
`endif
        tbl[3].nz   = 1'b1;
        tbl[3].last = 4'd1;
        // full-scale extremes: zigzag 5 -> raster 2, zigzag 15 -> raster 15
        tbl[4].lvl = put(put(256'd0, 5, 16'h7fff), 15, 16'h8000);
        tbl[4].qv  = fill(16'hffff);
`ifdef DQ_SATURATE_EN
        tbl[4].coef = put(put(256'd0, 2, 16'h7fff), 15, 16'h8000);
`else
        tbl[4].coef = put(put(256'd0, 2, 16'h8001), 15, 16'h8000);
`endif
        tbl[4].nz   = 1'b1;
        tbl[4].last = 4'd15;

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk("reset_coef", s, coef_w[s], 256'd0);
            chk("reset_flags", s, 256'({busy_w[s], nz_w[s], done_w[s], last_w[s]}), 256'd0);
        end
        @(negedge clk);
        rst_v = '1;

        for (int s = 0; s < 3; s++) begin
            for (int v = 0; v < 5; v++) begin
                run_block(s, tbl[v], $sformatf("vec%0d", v));
                if (v == 2) chk("coef15", s, 256'(coef_w[s][255:240]), 256'd112);
            end
            handshake(s);
            mid_reset(s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
